// File: rtl/icache_tag_ram_flush.sv
// Instruction-cache tag store: one write port, one registered read port, per-entry valid bit,
// hardware flush sweep (also run after reset), optional write-to-read bypass and parity check.
module icache_tag_ram_flush #(
  parameter int DATA_WIDTH = 25,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS_EN  = 1'b1,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_parity_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int MEM_W = DATA_WIDTH + (PARITY_EN ? 1 : 0);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [MEM_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    rd_perr_q;

  logic                    wr_accept;
  logic                    bypass_hit;
  logic [MEM_W-1:0]        wr_word;
  logic [MEM_W-1:0]        rd_word;
  logic                    rd_par_bad;

  assign wr_accept  = wr_en_i && (state_q == S_IDLE);
  assign bypass_hit = BYPASS_EN && rd_en_i && wr_accept && (rd_addr_i == wr_addr_i);
  assign rd_word    = mem_q[rd_addr_i];

  if (PARITY_EN) begin : g_par
    assign wr_word    = {^wr_data_i, wr_data_i};
    assign rd_par_bad = rd_word[DATA_WIDTH] != (^rd_word[DATA_WIDTH-1:0]);
  end else begin : g_nopar
    assign wr_word    = wr_data_i;
    assign rd_par_bad = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FLUSH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is deliberately unreset; validity comes only from the sweep.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_addr_i] <= wr_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_FLUSH) begin
      valid_q[cnt_q] <= 1'b0;
    end else if (wr_accept) begin
      valid_q[wr_addr_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
    end else if (rd_en_i) begin
      if (state_q == S_FLUSH) begin
        rd_data_q  <= rd_word[DATA_WIDTH-1:0];
        rd_valid_q <= 1'b0;
        rd_perr_q  <= 1'b0;
      end else if (bypass_hit) begin
        rd_data_q  <= wr_data_i;
        rd_valid_q <= wr_valid_i;
        rd_perr_q  <= 1'b0;
      end else begin
        rd_data_q  <= rd_word[DATA_WIDTH-1:0];
        rd_valid_q <= valid_q[rd_addr_i];
        rd_perr_q  <= valid_q[rd_addr_i] && rd_par_bad;
      end
    end
  end

  assign busy_o          = (state_q == S_FLUSH);
  assign rd_data_o       = rd_data_q;
  assign rd_valid_o      = rd_valid_q;
  assign rd_parity_err_o = rd_perr_q;

endmodule
